// File: rtl/io_port_responder.sv
// Port-I/O responder: GPIO register, TX/RX FIFOs and sticky status behind four CPU ports.
// Latency: writes take effect on the next clk; read data on `in` is registered (1 cycle).
// Backpressure: tx_valid/tx_ready drains TX; rx_ready drops when RX is full; a TX push to a full FIFO is dropped.
module io_port_responder #(
  parameter int          DEPTH     = 8,
  parameter logic [15:0] PORT_BASE = 16'h0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] base,
  input  logic [15:0] data,
  input  logic        flag,
  output logic [15:0] in,
  output logic [15:0] gpio_out,
  input  logic [15:0] gpio_in,
  output logic [15:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [15:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int             AW   = $clog2(DEPTH);
  localparam int             CW   = AW + 1;
  localparam logic [CW-1:0]  FULL = CW'(DEPTH);

  // Address decode: offset wraps in 16 bits, so addresses below PORT_BASE are never selected.
  logic [15:0] off;
  logic        sel;
  logic [1:0]  idx;
  logic        wr_gpio, wr_tx, wr_clr, wr_pop;

  assign off     = base - PORT_BASE;
  assign sel     = (off < 16'd4);
  assign idx     = off[1:0];
  assign wr_gpio = flag & sel & (idx == 2'd0);
  assign wr_tx   = flag & sel & (idx == 2'd1);
  assign wr_clr  = flag & sel & (idx == 2'd2);
  assign wr_pop  = flag & sel & (idx == 2'd3);

  // State registers
  logic [15:0]   in_q, in_d, gpio_q, gpio_d, sync1_q, sync1_d, sync2_q, sync2_d;
  logic [AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic          rx_ready_q, rx_ready_d, tx_ovf_q, tx_ovf_d, rx_udf_q, rx_udf_d;

  logic [15:0] tx_mem [DEPTH];
  logic [15:0] rx_mem [DEPTH];

  logic tx_push, tx_pop, rx_push, rx_pop;

  assign tx_valid = (tx_cnt_q != '0);
  assign tx_data  = tx_mem[tx_rptr_q];
  assign tx_pop   = tx_valid & tx_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign tx_push  = wr_tx & ((tx_cnt_q != FULL) | tx_pop);

  assign rx_ready = rx_ready_q;
  assign rx_push  = rx_valid & rx_ready_q;
  assign rx_pop   = wr_pop & (rx_cnt_q != '0);

  assign in       = in_q;
  assign gpio_out = gpio_q;

  // TX FIFO pointer and occupancy update
  always_comb begin
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    if (tx_push) tx_wptr_d = tx_wptr_q + 1'b1;
    if (tx_pop)  tx_rptr_d = tx_rptr_q + 1'b1;
    case ({tx_push, tx_pop})
      2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
      2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  // RX FIFO pointer and occupancy update; rx_ready follows the next count
  always_comb begin
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    rx_cnt_d  = rx_cnt_q;
    if (rx_push) rx_wptr_d = rx_wptr_q + 1'b1;
    if (rx_pop)  rx_rptr_d = rx_rptr_q + 1'b1;
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + 1'b1;
      2'b01:   rx_cnt_d = rx_cnt_q - 1'b1;
      default: rx_cnt_d = rx_cnt_q;
    endcase
    rx_ready_d = (rx_cnt_d != FULL);
  end

  // Sticky error bits: clear first so a same-cycle set wins
  always_comb begin
    tx_ovf_d = tx_ovf_q;
    rx_udf_d = rx_udf_q;
    if (wr_clr && data[0])           tx_ovf_d = 1'b0;
    if (wr_tx && !tx_push)           tx_ovf_d = 1'b1;
    if (wr_pop && (rx_cnt_q == '0))  rx_udf_d = 1'b1;
  end

  // GPIO register, input synchroniser and registered read mux
  always_comb begin
    gpio_d  = wr_gpio ? data : gpio_q;
    sync1_d = gpio_in;
    sync2_d = sync1_q;
    in_d    = 16'h0000;
    if (sel) begin
      case (idx)
        2'd0: in_d = sync2_q;
        2'd1: in_d = {8'h00, 8'(tx_cnt_q)};
        2'd2: in_d = {9'b0, (rx_cnt_q == FULL), (rx_cnt_q == '0), (tx_cnt_q == FULL),
                      (tx_cnt_q == '0), rx_udf_q, 1'b0, tx_ovf_q};
        default: in_d = (rx_cnt_q != '0) ? rx_mem[rx_rptr_q] : 16'h0000;
      endcase
    end
  end

  // Control state with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_q       <= '0;
      gpio_q     <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_cnt_q   <= '0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_cnt_q   <= '0;
      rx_ready_q <= 1'b0;
      tx_ovf_q   <= 1'b0;
      rx_udf_q   <= 1'b0;
    end else begin
      in_q       <= in_d;
      gpio_q     <= gpio_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_ready_q <= rx_ready_d;
      tx_ovf_q   <= tx_ovf_d;
      rx_udf_q   <= rx_udf_d;
    end
  end

  // FIFO storage needs no reset: contents are only visible while the count is non-zero
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wptr_q] <= data;
    if (rx_push) rx_mem[rx_wptr_q] <= rx_data;
  end

endmodule

// File: tb/tb_io_port_responder.sv
// Bench for io_port_responder: queue-based reference model plus directed literal checks.
// Latency: model predicts `in` one clk after the address is presented.
// Backpressure: drives tx_ready/rx_valid directly; producer holds data while rx_ready is low.
module tb_io_port_responder;

  localparam int          DEPTH = 8;
  localparam logic [15:0] PB    = 16'h0001;

  logic        clk, reset, flag, tx_valid, tx_ready, rx_valid, rx_ready;
  logic [15:0] base, data, dut_in, gpio_out, gpio_in, tx_data, rx_data;

  io_port_responder #(.DEPTH(DEPTH), .PORT_BASE(PB)) dut (
    .clk(clk), .reset(reset), .base(base), .data(data), .flag(flag), .in(dut_in),
    .gpio_out(gpio_out), .gpio_in(gpio_in), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Reference model: FIFOs as queues, status computed from their sizes.
  logic [15:0] tq[$];
  logic [15:0] rq[$];
  logic [15:0] m_in, m_gpio, s1, s2, mo;
  logic        m_ovf, m_udf, m_rx_ready;
  int          tn, rn;
  bit          tpop, wrs;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      tq.delete(); rq.delete();
      m_in = 16'h0; m_gpio = 16'h0; s1 = 16'h0; s2 = 16'h0;
      m_ovf = 1'b0; m_udf = 1'b0; m_rx_ready = 1'b0;
    end else begin
      mo  = base - PB;
      tn  = tq.size();
      rn  = rq.size();
      wrs = flag && (mo < 16'd4);
      if (mo == 16'd0)      m_in = s2;
      else if (mo == 16'd1) m_in = 16'(tn);
      else if (mo == 16'd2) m_in = {9'b0, rn == DEPTH, rn == 0, tn == DEPTH, tn == 0, m_udf, 1'b0, m_ovf};
      else if (mo == 16'd3) m_in = (rn > 0) ? rq[0] : 16'h0;
      else                  m_in = 16'h0;
      s2 = s1;
      s1 = gpio_in;
      tpop = (tn > 0) && tx_ready;
      if (tpop) void'(tq.pop_front());
      if (wrs && mo == 16'd0) m_gpio = data;
      if (wrs && mo == 16'd1) begin
        if (tn < DEPTH || tpop) tq.push_back(data);
        else m_ovf = 1'b1;
      end
      if (wrs && mo == 16'd2 && data[0]) m_ovf = 1'b0;
      if (wrs && mo == 16'd3) begin
        if (rn > 0) void'(rq.pop_front());
        else m_udf = 1'b1;
      end
      if (rx_valid && m_rx_ready) rq.push_back(rx_data);
      m_rx_ready = (rq.size() < DEPTH);
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("in", dut_in, m_in);
    chk("gpio_out", gpio_out, m_gpio);
    chk1("tx_valid", tx_valid, tq.size() != 0);
    chk1("rx_ready", rx_ready, m_rx_ready);
    if (tq.size() != 0) chk("tx_data", tx_data, tq[0]);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] o, input logic [15:0] d);
    base = PB + 16'(o);
    data = d;
    flag = 1'b1;
    tick();
    flag = 1'b0;
  endtask

  task automatic rd(input logic [1:0] o);
    base = PB + 16'(o);
    flag = 1'b0;
    tick();
  endtask

  logic [15:0] exp_v;

  initial begin
    reset = 1'b0; base = PB + 16'd2; data = 16'h0; flag = 1'b0;
    gpio_in = 16'h1111; tx_ready = 1'b0; rx_data = 16'h0; rx_valid = 1'b0;
    repeat (3) tick();
    chk("rst_in", dut_in, 16'h0000);
    chk1("rst_rx_ready", rx_ready, 1'b0);
    chk1("rst_tx_valid", tx_valid, 1'b0);

    // Release: status shows rx_empty (bit5) and tx_empty (bit3)
    reset = 1'b1;
    tick();
    chk("status_after_release", dut_in, 16'h0028);
    chk1("rx_ready_after_release", rx_ready, 1'b1);
    chk("gpio_after_release", gpio_out, 16'h0000);

    // GPIO write, out-of-range write ignored, synchroniser delay on read
    wr(2'd0, 16'hA5A5);
    chk("gpio_write", gpio_out, 16'hA5A5);
    base = 16'h0000; data = 16'h1111; flag = 1'b1;
    tick();
    flag = 1'b0;
    chk("gpio_unselected", gpio_out, 16'hA5A5);
    gpio_in = 16'h3C5A;
    rd(2'd0); rd(2'd0);
    chk("gpio_in_old", dut_in, 16'h1111);
    rd(2'd0);
    chk("gpio_in_new", dut_in, 16'h3C5A);

    // TX overflow: 9 writes into depth 8, last one dropped
    for (int i = 1; i <= 9; i++) wr(2'd1, 16'(i));
    rd(2'd1);
    chk("tx_count_full", dut_in, 16'h0008);
    rd(2'd2);
    chk("status_tx_full_ovf", dut_in, 16'h0031);
    tx_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk1("drain_valid", tx_valid, 1'b1);
      chk("drain_data", tx_data, 16'(k));
      tick();
    end
    chk1("drained_empty", tx_valid, 1'b0);
    tx_ready = 1'b0;
    wr(2'd2, 16'h0001);
    rd(2'd2);
    chk("status_ovf_cleared", dut_in, 16'h0028);

    // Push into a full TX while the head is popped
    for (int i = 0; i < 8; i++) wr(2'd1, 16'h0010 + 16'(i));
    base = PB + 16'd1; data = 16'h00FF; flag = 1'b1; tx_ready = 1'b1;
    tick();
    flag = 1'b0; tx_ready = 1'b0;
    rd(2'd1);
    chk("tx_count_full_pushpop", dut_in, 16'h0008);
    rd(2'd2);
    chk("status_no_ovf", dut_in, 16'h0030);
    tx_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_v = (k < 7) ? 16'h0011 + 16'(k) : 16'h00FF;
      chk("drain2_data", tx_data, exp_v);
      tick();
    end
    tx_ready = 1'b0;
    chk1("drained2_empty", tx_valid, 1'b0);

    // RX FIFO: head reads, simultaneous push/pop, underflow stays sticky
    rx_valid = 1'b1; rx_data = 16'h1234;
    tick();
    rx_data = 16'h5678;
    tick();
    rx_valid = 1'b0;
    rd(2'd3);
    chk("rx_head_1234", dut_in, 16'h1234);
    base = PB + 16'd3; flag = 1'b1; rx_valid = 1'b1; rx_data = 16'h9ABC;
    tick();
    flag = 1'b0; rx_valid = 1'b0;
    rd(2'd3);
    chk("rx_head_5678", dut_in, 16'h5678);
    wr(2'd3, 16'h0);
    rd(2'd3);
    chk("rx_head_9abc", dut_in, 16'h9ABC);
    wr(2'd3, 16'h0);
    rd(2'd3);
    chk("rx_head_empty", dut_in, 16'h0000);
    wr(2'd3, 16'h0);
    rd(2'd2);
    chk("status_underflow", dut_in, 16'h002C);
    wr(2'd2, 16'hFFFF);
    rd(2'd2);
    chk("status_underflow_kept", dut_in, 16'h002C);

    // Fill RX, then reset in the middle of the burst
    for (int i = 1; i <= 3; i++) wr(2'd1, 16'h0A00 + 16'(i));
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 16'h00A0 + 16'(i);
      tick();
    end
    chk1("rx_full_not_ready", rx_ready, 1'b0);
    rx_data = 16'h00A8;
    tick(); tick();
    chk1("rx_full_hold", rx_ready, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk1("midrst_tx_valid", tx_valid, 1'b0);
    chk1("midrst_rx_ready", rx_ready, 1'b0);
    chk("midrst_gpio", gpio_out, 16'h0000);
    chk("midrst_in", dut_in, 16'h0000);
    tick();
    rx_valid = 1'b0;
    tick();
    reset = 1'b1;
    base = PB + 16'd2;
    tick();
    chk("status_after_midrst", dut_in, 16'h0028);
    chk1("rx_ready_after_midrst", rx_ready, 1'b1);
    chk1("tx_valid_after_midrst", tx_valid, 1'b0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
